// File: rtl/core_sequencer_pkg.sv
// core_sequencer_pkg: core status command encoding and sequencer state enumeration.
package core_sequencer_pkg;
  localparam logic [1:0] ST_HOLD  = 2'b00;
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_STOP  = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_FINISH, S_ABORT} seq_state_e;
endpackage

// File: rtl/core_sequencer_edge_latch.sv
// edge_latch: rising-edge detector on a core's end_process with a sticky, clearable done latch.
module edge_latch (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic level,
  output logic fin
);
  logic prev, lat;
  // History follows the level every cycle, so a level already high at launch never counts.
  assign fin = lat | (en & level & ~prev);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      prev <= 1'b0;
      lat  <= 1'b0;
    end else begin
      prev <= level;
      lat  <= clr ? 1'b0 : fin;
    end
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: launches enabled cores, tracks per-core completion and bounds the run with a timeout.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_CORES-1:0]   core_mask,
  input  logic [NUM_CORES-1:0]   end_process,
  output logic [2*NUM_CORES-1:0] status,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [TIMEOUT_W-1:0]   run_cycles
);
  if (NUM_CORES < 1 || NUM_CORES > 8 || TIMEOUT_W < 4) begin : g_bad_params
    $error("core_sequencer: NUM_CORES must be 1..8 and TIMEOUT_W must be >= 4");
  end

  seq_state_e             state;
  logic [NUM_CORES-1:0]   mask, fin;
  logic                   accept, all_fin;
  logic [TIMEOUT_W-1:0]   cyc_nxt;

  assign accept  = (state == S_IDLE) && start && |core_mask;
  assign all_fin = &(fin | ~mask);
  assign cyc_nxt = run_cycles + 1'b1;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    edge_latch u_latch (
      .clock (clock),
      .reset (reset),
      .clr   (accept),
      .en    ((state == S_RUN) && mask[i]),
      .level (end_process[i]),
      .fin   (fin[i])
    );
  end

  // Disabled cores always see HOLD; enabled cores get `off` once finished, else `on`.
  function automatic logic [2*NUM_CORES-1:0] cmds(input logic [NUM_CORES-1:0] en,
                                                  input logic [NUM_CORES-1:0] f,
                                                  input logic [1:0] on,
                                                  input logic [1:0] off);
    cmds = '0;
    for (int i = 0; i < NUM_CORES; i++) cmds[2*i+:2] = en[i] ? (f[i] ? off : on) : ST_HOLD;
  endfunction

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state      <= S_IDLE;
      mask       <= '0;
      status     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      run_cycles <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          state      <= S_ARM;
          busy       <= 1'b1;
          mask       <= core_mask;
          timeout    <= 1'b0;
          run_cycles <= '0;
          status     <= cmds(core_mask, '0, ST_START, ST_START);
        end
        S_ARM: begin
          state  <= S_RUN;
          status <= cmds(mask, '0, ST_RUN, ST_RUN);
        end
        S_RUN: begin
          run_cycles <= cyc_nxt;
          // Completion takes priority over the all-ones count in the same cycle.
          if (all_fin || cyc_nxt == '1) begin
            state   <= all_fin ? S_FINISH : S_ABORT;
            done    <= all_fin;
            timeout <= !all_fin;
            status  <= cmds(mask, '1, ST_RUN, ST_STOP);
          end else status <= cmds(mask, fin, ST_RUN, ST_STOP);
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          status <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed checks of core_sequencer with 4 cores and a 4-bit run counter.
module tb_core_sequencer;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] core_mask = '0;
  logic [3:0] end_process = '0;
  logic [7:0] status;
  logic       busy, done, timeout;
  logic [3:0] run_cycles;
  int vectors = 0;
  int errors = 0;

  core_sequencer #(.NUM_CORES(4), .TIMEOUT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .core_mask   (core_mask),
    .end_process (end_process),
    .status      (status),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .run_cycles  (run_cycles)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_status", status, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cycles", run_cycles, 0);

    // Normal 4-core run: edges at RUN cycles 5, 9, 9, 12
    start = 1'b1; core_mask = 4'hF;
    step();
    start = 1'b0;
    chk("n_arm_status", status, 8'h55);
    chk("n_arm_busy", busy, 1);
    step();
    chk("n_run_status", status, 8'hAA);
    chk("n_run_cycles0", run_cycles, 0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) end_process[0] = 1'b1;
      if (k == 9) end_process[2:1] = 2'b11;
      if (k == 12) end_process[3] = 1'b1;
      step();
      if (k == 5) chk("n_core0_stop", status, 8'hAB);
      if (k == 9) chk("n_core12_stop", status, 8'hBF);
      if (k == 11) chk("n_no_early_done", done, 0);
    end
    chk("n_fin_status", status, 8'hFF);
    chk("n_fin_done", done, 1);
    chk("n_fin_cycles", run_cycles, 12);
    chk("n_fin_timeout", timeout, 0);
    step();
    chk("n_idle_status", status, 8'h00);
    chk("n_idle_done", done, 0);
    chk("n_idle_busy", busy, 0);
    chk("n_idle_cycles", run_cycles, 12);

    // Partial mask 0101 with core 1 toggling
    end_process = '0;
    step();
    start = 1'b1; core_mask = 4'b0101;
    step();
    start = 1'b0;
    chk("p_arm_status", status, 8'h11);
    step();
    chk("p_run_status", status, 8'h22);
    for (int k = 1; k <= 6; k++) begin
      end_process[1] = k[0];
      if (k == 5) end_process[0] = 1'b1;
      if (k == 6) end_process[2] = 1'b1;
      step();
      if (k == 4) chk("p_toggle_hold", status, 8'h22);
      if (k == 5) chk("p_core0_stop", status, 8'h23);
    end
    chk("p_fin_status", status, 8'h33);
    chk("p_fin_done", done, 1);
    chk("p_fin_cycles", run_cycles, 6);
    step();
    chk("p_idle_busy", busy, 0);

    // Stale high end_process before start
    end_process = 4'hF;
    step();
    step();
    start = 1'b1; core_mask = 4'hF;
    step();
    start = 1'b0;
    chk("s_arm_status", status, 8'h55);
    step();
    for (int k = 1; k <= 3; k++) step();
    chk("s_stale_status", status, 8'hAA);
    chk("s_stale_done", done, 0);
    end_process = 4'h0;
    step();
    chk("s_fall_status", status, 8'hAA);
    end_process = 4'hF;
    step();
    chk("s_fin_status", status, 8'hFF);
    chk("s_fin_done", done, 1);
    chk("s_fin_cycles", run_cycles, 5);
    step();

    // Timeout: core 2 never finishes
    end_process = '0;
    step();
    start = 1'b1; core_mask = 4'hF;
    step();
    start = 1'b0;
    step();
    for (int k = 1; k <= 15; k++) begin
      if (k == 2) end_process = 4'b1011;
      step();
      if (k == 2) chk("t_partial_stop", status, 8'hEF);
      if (k == 14) begin
        chk("t_pre_cycles", run_cycles, 14);
        chk("t_pre_timeout", timeout, 0);
      end
    end
    chk("t_abort_status", status, 8'hFF);
    chk("t_abort_timeout", timeout, 1);
    chk("t_abort_cycles", run_cycles, 15);
    chk("t_abort_done", done, 0);
    chk("t_abort_busy", busy, 1);
    step();
    chk("t_idle_status", status, 8'h00);
    chk("t_sticky_timeout", timeout, 1);
    chk("t_idle_cycles", run_cycles, 15);

    // Ignored starts and completion tying with the all-ones count
    end_process = '0;
    start = 1'b1; core_mask = 4'h0;
    step();
    chk("i_mask0_busy", busy, 0);
    chk("i_mask0_timeout", timeout, 1);
    core_mask = 4'b0101;
    step();
    chk("i_arm_status", status, 8'h11);
    chk("i_arm_timeout", timeout, 0);
    chk("i_arm_cycles", run_cycles, 0);
    core_mask = 4'hF;
    step();
    chk("i_run_status", status, 8'h22);
    for (int k = 1; k <= 15; k++) begin
      start = k[0];
      if (k >= 5) end_process[0] = 1'b1;
      if (k == 15) end_process[2] = 1'b1;
      step();
      if (k == 14) begin
        chk("i_pre_status", status, 8'h23);
        chk("i_pre_done", done, 0);
      end
    end
    start = 1'b0;
    chk("i_tie_status", status, 8'h33);
    chk("i_tie_done", done, 1);
    chk("i_tie_timeout", timeout, 0);
    chk("i_tie_cycles", run_cycles, 15);
    step();
    chk("i_idle_done", done, 0);
    chk("i_idle_busy", busy, 0);

    // Asynchronous reset mid-run
    end_process = '0;
    start = 1'b1; core_mask = 4'hF;
    step();
    start = 1'b0;
    step();
    step();
    chk("r_run_cycles", run_cycles, 1);
    reset = 1'b1;
    #1;
    chk("r_status", status, 8'h00);
    chk("r_busy", busy, 0);
    chk("r_cycles", run_cycles, 0);
    chk("r_done", done, 0);
    step();
    chk("r_hold_done", done, 0);
    reset = 1'b0;
    step();
    chk("r_after_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Run-control block that sits directly upstream of the matrix-multiplication cores and drives each core's `status[1:0]` input. It collects every core's `end_process` output. On a top-level `start`, it launches the enabled cores, tracks per-core completion, and bounds the run with a timeout. It then stops all cores and reports `done` or `timeout` together with a cycle count.

## Interface
- `NUM_CORES`, default 4: number of cores controlled (1..8).
- `TIMEOUT_W`, default 16: width of the run-cycle counter. The timeout fires at all-ones.
- `clock` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: launch request, sampled in IDLE only.
- `core_mask` input NUM_CORES: enabled cores, sampled with `start`.
- `end_process` input NUM_CORES: per-core completion, bit i from core i.
- `status` output 2*NUM_CORES: per-core command, bits [2i+1:2i] drive core i.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse on normal completion.
- `timeout` output 1: sticky abort flag, cleared on the next accepted start.
- `run_cycles` output TIMEOUT_W: RUN-state cycle count of the last/current run.

## Operation
- Status encoding, shared with control_unit: HOLD=2'b00, START=2'b01, RUN=2'b10, STOP=2'b11.
- **States:** IDLE, ARM, RUN, FINISH, ABORT.
- **IDLE**
  - All status = HOLD.
  - `start` with `core_mask`≠0: latch the mask, clear the done latches, `run_cycles` and `timeout`, then go to ARM.
  - `start` with mask=0 is ignored.
- **ARM** (1 cycle)
  - Enabled cores get START; disabled cores get HOLD.
  - Capture `end_process` into the edge-detect history register, so a stale level is not counted as done.
  - Go to RUN.
- **RUN**
  - Enabled, not-yet-done cores get RUN.
  - A core whose done latch is set gets STOP. Disabled cores get HOLD.
  - A done latch sets on a rising edge of `end_process[i]` for an enabled core. Edges on disabled cores are ignored.
  - `run_cycles` increments every RUN cycle.
  - When all enabled latches are set (including the latch setting this cycle), go to FINISH.
  - Otherwise, when `run_cycles` equals all-ones, go to ABORT.
  - If completion and the all-ones count happen in the same cycle, completion wins and the next state is FINISH.
- **FINISH** (1 cycle)
  - All enabled cores get STOP.
  - `done`=1.
  - Go to IDLE.
- **ABORT** (1 cycle)
  - All enabled cores get STOP.
  - `timeout` set.
  - Go to IDLE.
- `start` outside IDLE is ignored; there is no queuing.
- `run_cycles` and `timeout` hold their values in IDLE until the next accepted start.

## Timing
- **Reset values:** state=IDLE; status all HOLD; busy=0, done=0, timeout=0; run_cycles=0; latches and mask=0.
- Reset asserted mid-run forces IDLE/HOLD immediately (asynchronously). No STOP is issued.
- All outputs are registered.
- `start` high at edge t: ARM status is visible after edge t, and RUN status after edge t+1.
- `end_process` rising edge sampled at edge u: that core's status changes to STOP after edge u.
- The last core's edge sampled at u: FINISH (done=1, STOP) for cycle u..u+1, then IDLE after u+1.
- Minimum start-to-done latency is 3 cycles (ARM, one RUN, FINISH).
- `done` is exactly one cycle wide.
- `start` may be re-accepted the cycle after FINISH or ABORT.

## Structure
- Shared package holds:
  - the status encoding constants (HOLD/START/RUN/STOP), shared with control_unit;
  - the sequencer state enumeration.
- One sub-module, `edge_latch`: a per-core rising-edge detector plus sticky latch with a clear input. Instantiate it NUM_CORES times in a generate loop.
- Parameter checks: 1 ≤ NUM_CORES ≤ 8 and TIMEOUT_W ≥ 4.

## Test plan
- **Reset:** assert reset mid-RUN with NUM_CORES=4 -> status=8'h00, busy=0, run_cycles=0 immediately; no done pulse.
- **Normal 4-core run:** mask=4'b1111; cores end at RUN cycles 5, 9, 9 and 12 -> each core's status goes to STOP one cycle after its edge; done pulses once; run_cycles=12; timeout=0.
- **Partial mask:** mask=4'b0101; `end_process[1]` toggles during RUN -> cores 1 and 3 stay HOLD throughout; completion depends only on cores 0 and 2.
- **Stale done level:** `end_process`=4'b1111 held high before start -> no completion until each bit falls and rises again.
- **Timeout:** TIMEOUT_W=4, core 2 never finishes -> ABORT after 15 RUN cycles; all enabled status=STOP for one cycle; timeout=1, run_cycles=15.
- **Ignored starts and tie:**
  - start pulses during RUN and with mask=0 -> no effect.
  - last completion in the same cycle as the all-ones count -> done=1, timeout=0.
